perf_monitor: RTL and testbench
===============================

PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 SHALL have parameter NUM_EVENTS, default 4, number of event counters (1..15).
REQ-002 SHALL have parameter CNT_W, default 32, width of every counter and of limit_i/rd_data_o.
REQ-003 SHALL have ports:
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- clear_i  in  1  synchronous clear of counters/flags; return to IDLE.
- start_i  in  1  start a measurement window.
- stop_i  in  1  end the window early.
- limit_i  in  CNT_W  cycle limit, sampled at start; 0 = unlimited.
- event_i  in  NUM_EVENTS  per-cycle event strobes (stall, flush, ...).
- sel_i  in  4  read select; 0 = cycle counter, k = event counter k-1.
- rd_data_o  out  CNT_W  selected counter value.
- ovf_o  out  NUM_EVENTS+1  sticky saturation flags; bit 0 = cycle counter.
- running_o  out  1  high in RUN.
- done_o  out  1  one-cycle pulse on entry to DONE.

Function
REQ-004 SHALL implement states IDLE, RUN, DONE.
REQ-005 IDLE or DONE with start_i=1 SHALL zero all counters and ovf_o, latch limit_i, and enter RUN next cycle; the start cycle SHALL NOT be counted.
REQ-006 start_i in RUN SHALL be ignored.
REQ-007 In RUN, each cycle SHALL increment the cycle counter by 1 and event counter k by 1 when event_i[k]=1.
REQ-008 RUN SHALL go to DONE on the edge at which the cycle counter becomes equal to a non-zero latched limit; that final cycle SHALL be counted.
REQ-009 stop_i=1 in RUN SHALL go to DONE; events and the cycle in the stop cycle SHALL NOT be counted; stop_i SHALL take precedence over limit reach.
REQ-010 stop_i in IDLE or DONE SHALL be ignored.
REQ-011 done_o SHALL be high exactly in the first cycle spent in DONE.
REQ-012 DONE SHALL hold all counters frozen until start_i or clear_i.
REQ-013 Each counter SHALL saturate at 2^CNT_W-1, never wrap, and set its ovf_o bit on the attempted increment beyond saturation; ovf_o bits are sticky until start, clear or reset.
REQ-014 clear_i SHALL zero counters, ovf_o and latched limit and force IDLE in any state; priority: reset > clear_i > stop_i > start_i.
REQ-015 rd_data_o SHALL be registered: value of counter sel_i as of the previous edge, one-cycle latency; sel_i > NUM_EVENTS SHALL return 0.
REQ-016 Reading SHALL be legal in every state and SHALL NOT disturb counting.
REQ-017 running_o SHALL be combinational from state (high iff RUN).

Reset
REQ-018 rst_i=0 at a rising edge SHALL force IDLE, all counters 0, latched limit 0, ovf_o 0, rd_data_o 0, done_o 0, running_o 0.
REQ-019 Reset asserted mid-RUN SHALL discard the window without a done_o pulse.

Structure
REQ-020 Shared package perf_pkg SHALL hold the state enum (IDLE=0, RUN=1, DONE=2) and default NUM_EVENTS/CNT_W constants.
REQ-021 Sub-module perf_counter (saturating counter with inc, clr, sat flag) SHALL be instantiated NUM_EVENTS+1 times.

Verification
REQ-022 limit_i=64, start_i pulse, event_i[0] high on cycles 5-7 of the window -> done_o after 64 counted cycles; sel 0 reads 64, sel 1 reads 3.
REQ-023 limit_i=0, start, stop_i on the 10th RUN cycle -> DONE; cycle counter 9; events on the stop cycle not counted.
REQ-024 CNT_W=4, limit_i=0, event_i[1] held high 20 cycles -> sel 2 reads 15, ovf_o[2]=1, other ovf bits 0.
REQ-025 clear_i and start_i in the same cycle during RUN -> IDLE, counters 0, no done_o.
REQ-026 rst_i=0 on the 3rd RUN cycle -> all outputs 0 next cycle; re-start with limit_i=5 -> done_o exactly 5 cycles after entering RUN.
REQ-027 sel_i=7 with NUM_EVENTS=4 -> rd_data_o=0 one cycle later.

Source files
------------

// File: rtl/perf_pkg.sv
// perf_pkg: shared definitions for the performance monitor.
//   state_e          window FSM encoding (IDLE=0, RUN=1, DONE=2)
//   DEF_NUM_EVENTS   default number of event counters
//   DEF_CNT_W        default counter width
//   SEL_W            width of the read-select bus
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_NUM_EVENTS = 4;
  localparam int DEF_CNT_W      = 32;
  localparam int SEL_W          = 4;

endpackage

// File: rtl/perf_if.sv
// perf_if: control, event and readback signals of the performance monitor.
//   clear_i    synchronous clear, back to IDLE
//   start_i    open a measurement window
//   stop_i     close the window early
//   limit_i    cycle limit sampled at start (0 = unlimited)
//   event_i    per-cycle event strobes
//   sel_i      read select (0 = cycle counter, k = event counter k-1)
//   rd_data_o  registered value of the selected counter
//   ovf_o      sticky saturation flags, bit 0 = cycle counter
//   running_o  high while the window is open
//   done_o     one-cycle pulse on entry to DONE
// master = the agent driving the monitor, slave = the monitor itself.
interface perf_if
  import perf_pkg::*;
#(
  parameter int NUM_EVENTS = DEF_NUM_EVENTS,
  parameter int CNT_W      = DEF_CNT_W
) ();

  logic                  clear_i;
  logic                  start_i;
  logic                  stop_i;
  logic [CNT_W-1:0]      limit_i;
  logic [NUM_EVENTS-1:0] event_i;
  logic [SEL_W-1:0]      sel_i;
  logic [CNT_W-1:0]      rd_data_o;
  logic [NUM_EVENTS:0]   ovf_o;
  logic                  running_o;
  logic                  done_o;

  modport master (
    output clear_i, start_i, stop_i, limit_i, event_i, sel_i,
    input  rd_data_o, ovf_o, running_o, done_o
  );

  modport slave (
    input  clear_i, start_i, stop_i, limit_i, event_i, sel_i,
    output rd_data_o, ovf_o, running_o, done_o
  );

endinterface

// File: rtl/perf_counter.sv
// perf_counter: saturating up-counter with a sticky saturation flag.
//   clk   clock
//   rst   synchronous active-low reset
//   clr   synchronous clear of count and flag
//   inc   increment request for this cycle
//   cnt   current count
//   sat   set when an increment is attempted while already at all-ones
module perf_counter
  import perf_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  // Returns {overflow, next_count}; holds at all-ones instead of wrapping.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] value);
    if (&value) begin
      return {1'b1, value};
    end
    return {1'b0, value + CNT_W'(1)};
  endfunction

  logic [CNT_W:0] step;

  assign step = sat_inc(cnt);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc) begin
      cnt <= step[CNT_W-1:0];
      sat <= sat | step[CNT_W];
    end
  end

endmodule

// File: rtl/perf_monitor.sv
// perf_monitor: windowed cycle/event counter block.
//   clk_i  clock
//   rst_i  synchronous active-low reset
//   bus    perf_if slave port (control, events, readback, status)
// One cycle counter plus NUM_EVENTS event counters run while in RUN. A window
// ends on stop_i (that cycle not counted) or when the cycle counter reaches a
// non-zero limit (that cycle counted). Counters freeze in DONE.
module perf_monitor
  import perf_pkg::*;
#(
  parameter int NUM_EVENTS = DEF_NUM_EVENTS,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic clk_i,
  input  logic rst_i,
  perf_if.slave bus
);

  state_e           state;
  state_e           state_n;
  logic [CNT_W-1:0] limit_q;
  logic             count_en;
  logic             clr_all;
  logic             load_lim;
  logic             done_n;
  logic             done_q;
  logic [CNT_W-1:0] rd_data_p0;
  logic [CNT_W-1:0] rd_data_p1;
  logic [CNT_W-1:0] cnt [NUM_EVENTS+1];
  logic [NUM_EVENTS:0] sat;

  // Priority: clear > stop > start (reset handled in the registers).
  always_comb begin
    state_n  = state;
    count_en = 1'b0;
    clr_all  = 1'b0;
    load_lim = 1'b0;
    done_n   = 1'b0;
    if (bus.clear_i) begin
      state_n = IDLE;
      clr_all = 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start_i) begin
            state_n  = RUN;
            clr_all  = 1'b1;
            load_lim = 1'b1;
          end
        end
        RUN: begin
          if (bus.stop_i) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            count_en = 1'b1;
            // This increment makes the cycle counter equal to the limit.
            if ((limit_q != '0) && (cnt[0] == limit_q - CNT_W'(1))) begin
              state_n = DONE;
              done_n  = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      done_q  <= 1'b0;
      limit_q <= '0;
    end else begin
      state  <= state_n;
      done_q <= done_n;
      if (bus.clear_i) begin
        limit_q <= '0;
      end else if (load_lim) begin
        limit_q <= bus.limit_i;
      end
    end
  end

  // Counter 0 counts cycles, counter k counts event_i[k-1].
  for (genvar g = 0; g <= NUM_EVENTS; g++) begin : g_cnt
    logic inc;
    if (g == 0) begin : g_cyc
      assign inc = count_en;
    end else begin : g_evt
      assign inc = count_en & bus.event_i[g-1];
    end
    perf_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk (clk_i),
      .rst (rst_i),
      .clr (clr_all),
      .inc (inc),
      .cnt (cnt[g]),
      .sat (sat[g])
    );
  end

  // Stage p0: read-select mux; out-of-range selects return zero.
  always_comb begin
    rd_data_p0 = '0;
    for (int i = 0; i <= NUM_EVENTS; i++) begin
      if (int'(bus.sel_i) == i) begin
        rd_data_p0 = cnt[i];
      end
    end
  end

  // Stage p1: registered readback.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rd_data_p1 <= '0;
    end else begin
      rd_data_p1 <= rd_data_p0;
    end
  end

  assign bus.rd_data_o = rd_data_p1;
  assign bus.ovf_o     = sat;
  assign bus.running_o = (state == RUN);
  assign bus.done_o    = done_q;

endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: directed bench for perf_monitor. A 32-bit instance covers
// windows, stop, clear, reset and readback; a 4-bit instance covers saturation.
module tb_perf_monitor;
  import perf_pkg::*;

  localparam int NE  = 4;
  localparam int CW  = 32;
  localparam int CW4 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  perf_if #(.NUM_EVENTS(NE), .CNT_W(CW))  bus  ();
  perf_if #(.NUM_EVENTS(NE), .CNT_W(CW4)) bus4 ();

  perf_monitor #(.NUM_EVENTS(NE), .CNT_W(CW)) u_dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  perf_monitor #(.NUM_EVENTS(NE), .CNT_W(CW4)) u_dut4 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clear_i  = 1'b0; bus.start_i  = 1'b0; bus.stop_i  = 1'b0;
    bus.limit_i  = '0;   bus.event_i  = '0;   bus.sel_i   = '0;
    bus4.clear_i = 1'b0; bus4.start_i = 1'b0; bus4.stop_i = 1'b0;
    bus4.limit_i = '0;   bus4.event_i = '0;   bus4.sel_i  = '0;
  endtask

  // Leaves the bench in RUN cycle 1 of a new window.
  task automatic start_window(input logic [CW-1:0] lim);
    bus.limit_i = lim;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (bus.running_o !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", bus.running_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
    checks++; if (bus.ovf_o !== 5'b0) begin errors++; $display("FAIL reset_ovf: got %b want 00000", bus.ovf_o); end
    checks++; if (bus.rd_data_o !== 32'd0) begin errors++; $display("FAIL reset_rd: got %0d want 0", bus.rd_data_o); end
    checks++; if (bus4.ovf_o !== 5'b0) begin errors++; $display("FAIL reset_ovf4: got %b want 00000", bus4.ovf_o); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_limit();
    int early_done = 0;
    int not_running = 0;
    start_window(32'd64);
    for (int n = 1; n <= 64; n++) begin
      bus.event_i = (n >= 5 && n <= 7) ? 4'b0001 : 4'b0000;
      if (bus.done_o !== 1'b0) early_done++;
      if (bus.running_o !== 1'b1) not_running++;
      tick();
    end
    bus.event_i = '0;
    checks++; if (early_done !== 0) begin errors++; $display("FAIL limit_early_done: got %0d want 0", early_done); end
    checks++; if (not_running !== 0) begin errors++; $display("FAIL limit_running: got %0d idle cycles want 0", not_running); end
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL limit_done: got %b want 1", bus.done_o); end
    checks++; if (bus.running_o !== 1'b0) begin errors++; $display("FAIL limit_stopped: got %b want 0", bus.running_o); end
    bus.sel_i = 4'd0;
    tick();
    checks++; if (bus.rd_data_o !== 32'd64) begin errors++; $display("FAIL limit_cycles: got %0d want 64", bus.rd_data_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL limit_done_pulse: got %b want 0", bus.done_o); end
    bus.event_i = 4'b0001;
    bus.sel_i = 4'd1;
    tick();
    checks++; if (bus.rd_data_o !== 32'd3) begin errors++; $display("FAIL limit_events: got %0d want 3", bus.rd_data_o); end
    tick();
    tick();
    checks++; if (bus.rd_data_o !== 32'd3) begin errors++; $display("FAIL done_frozen: got %0d want 3", bus.rd_data_o); end
    bus.event_i = '0;
  endtask

  task automatic test_stop();
    start_window(32'd0);
    for (int n = 1; n <= 10; n++) begin
      bus.event_i = (n == 10) ? 4'b1111 : 4'b0100;
      bus.stop_i  = (n == 10);
      tick();
    end
    bus.stop_i = 1'b0;
    bus.event_i = '0;
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL stop_done: got %b want 1", bus.done_o); end
    bus.sel_i = 4'd0; tick();
    checks++; if (bus.rd_data_o !== 32'd9) begin errors++; $display("FAIL stop_cycles: got %0d want 9", bus.rd_data_o); end
    bus.sel_i = 4'd3; tick();
    checks++; if (bus.rd_data_o !== 32'd9) begin errors++; $display("FAIL stop_ev2: got %0d want 9", bus.rd_data_o); end
    bus.sel_i = 4'd1; tick();
    checks++; if (bus.rd_data_o !== 32'd0) begin errors++; $display("FAIL stop_ev0: got %0d want 0", bus.rd_data_o); end
    bus.sel_i = 4'd4; tick();
    checks++; if (bus.rd_data_o !== 32'd0) begin errors++; $display("FAIL stop_ev3: got %0d want 0", bus.rd_data_o); end
    // stop_i outside RUN has no effect.
    bus.stop_i = 1'b1; tick(); bus.stop_i = 1'b0;
    checks++; if ({bus.running_o, bus.done_o} !== 2'b00) begin errors++; $display("FAIL stop_in_done: got %b want 00", {bus.running_o, bus.done_o}); end
    // stop_i beats reaching the limit in the same cycle.
    start_window(32'd3);
    tick();
    tick();
    bus.stop_i = 1'b1; tick(); bus.stop_i = 1'b0;
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL stop_prec_done: got %b want 1", bus.done_o); end
    bus.sel_i = 4'd0; tick();
    checks++; if (bus.rd_data_o !== 32'd2) begin errors++; $display("FAIL stop_prec_cycles: got %0d want 2", bus.rd_data_o); end
  endtask

  task automatic test_saturation();
    bus4.limit_i = '0;
    bus4.start_i = 1'b1; tick(); bus4.start_i = 1'b0;
    bus4.event_i = 4'b0010;
    for (int n = 1; n <= 20; n++) begin
      if (n == 16) begin
        checks++; if (bus4.ovf_o !== 5'b00000) begin errors++; $display("FAIL sat_at_max: got %b want 00000", bus4.ovf_o); end
      end
      if (n == 17) begin
        checks++; if (bus4.ovf_o !== 5'b00101) begin errors++; $display("FAIL sat_past_max: got %b want 00101", bus4.ovf_o); end
      end
      tick();
    end
    bus4.event_i = '0;
    bus4.stop_i = 1'b1; tick(); bus4.stop_i = 1'b0;
    // The cycle counter also passes 15 in this window, so bit 0 is set too.
    checks++; if (bus4.ovf_o !== 5'b00101) begin errors++; $display("FAIL sat_ovf: got %b want 00101", bus4.ovf_o); end
    bus4.sel_i = 4'd2; tick();
    checks++; if (bus4.rd_data_o !== 4'd15) begin errors++; $display("FAIL sat_ev1: got %0d want 15", bus4.rd_data_o); end
    bus4.sel_i = 4'd0; tick();
    checks++; if (bus4.rd_data_o !== 4'd15) begin errors++; $display("FAIL sat_cycles: got %0d want 15", bus4.rd_data_o); end
    bus4.sel_i = 4'd1; tick();
    checks++; if (bus4.rd_data_o !== 4'd0) begin errors++; $display("FAIL sat_ev0: got %0d want 0", bus4.rd_data_o); end
    bus4.start_i = 1'b1; tick(); bus4.start_i = 1'b0;
    checks++; if (bus4.ovf_o !== 5'b00000) begin errors++; $display("FAIL sat_restart_ovf: got %b want 00000", bus4.ovf_o); end
    bus4.stop_i = 1'b1; tick(); bus4.stop_i = 1'b0;
  endtask

  task automatic test_clear();
    int done_seen = 0;
    start_window(32'd0);
    bus.event_i = 4'b0001;
    for (int n = 1; n <= 4; n++) tick();
    bus.clear_i = 1'b1;
    bus.start_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    bus.start_i = 1'b0;
    bus.event_i = '0;
    if (bus.done_o !== 1'b0) done_seen++;
    checks++; if (bus.running_o !== 1'b0) begin errors++; $display("FAIL clear_running: got %b want 0", bus.running_o); end
    checks++; if (bus.ovf_o !== 5'b0) begin errors++; $display("FAIL clear_ovf: got %b want 00000", bus.ovf_o); end
    bus.sel_i = 4'd0; tick();
    if (bus.done_o !== 1'b0) done_seen++;
    checks++; if (bus.rd_data_o !== 32'd0) begin errors++; $display("FAIL clear_cycles: got %0d want 0", bus.rd_data_o); end
    bus.sel_i = 4'd1; tick();
    if (bus.done_o !== 1'b0) done_seen++;
    checks++; if (bus.rd_data_o !== 32'd0) begin errors++; $display("FAIL clear_ev0: got %0d want 0", bus.rd_data_o); end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL clear_no_done: got %0d pulses want 0", done_seen); end
  endtask

  task automatic test_reset_midrun();
    int early_done = 0;
    bus.sel_i = 4'd0;
    start_window(32'd0);
    bus.event_i = 4'b1000;
    tick();
    tick();
    checks++; if (bus.rd_data_o !== 32'd1) begin errors++; $display("FAIL read_latency: got %0d want 1", bus.rd_data_o); end
    rst_n = 1'b0;
    tick();
    checks++; if ({bus.running_o, bus.done_o} !== 2'b00) begin errors++; $display("FAIL midrst_status: got %b want 00", {bus.running_o, bus.done_o}); end
    checks++; if (bus.rd_data_o !== 32'd0) begin errors++; $display("FAIL midrst_rd: got %0d want 0", bus.rd_data_o); end
    checks++; if (bus.ovf_o !== 5'b0) begin errors++; $display("FAIL midrst_ovf: got %b want 00000", bus.ovf_o); end
    rst_n = 1'b1;
    bus.event_i = '0;
    tick();
    checks++; if ({bus.running_o, bus.done_o} !== 2'b00) begin errors++; $display("FAIL midrst_after: got %b want 00", {bus.running_o, bus.done_o}); end
    // Restart with limit 5; a start pulse mid-window must be ignored.
    start_window(32'd5);
    for (int k = 1; k <= 5; k++) begin
      bus.start_i = (k == 3);
      bus.limit_i = (k == 3) ? 32'd100 : 32'd5;
      if (bus.done_o !== 1'b0) early_done++;
      tick();
    end
    bus.start_i = 1'b0;
    checks++; if (early_done !== 0) begin errors++; $display("FAIL restart_early_done: got %0d want 0", early_done); end
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL restart_done: got %b want 1", bus.done_o); end
    tick();
    checks++; if (bus.rd_data_o !== 32'd5) begin errors++; $display("FAIL restart_cycles: got %0d want 5", bus.rd_data_o); end
  endtask

  task automatic test_sel_range();
    bus.sel_i = 4'd7; tick();
    checks++; if (bus.rd_data_o !== 32'd0) begin errors++; $display("FAIL sel7: got %0d want 0", bus.rd_data_o); end
    bus.sel_i = 4'd5; tick();
    checks++; if (bus.rd_data_o !== 32'd0) begin errors++; $display("FAIL sel5: got %0d want 0", bus.rd_data_o); end
    bus.sel_i = 4'd15; tick();
    checks++; if (bus.rd_data_o !== 32'd0) begin errors++; $display("FAIL sel15: got %0d want 0", bus.rd_data_o); end
    bus.sel_i = 4'd0; tick();
    checks++; if (bus.rd_data_o !== 32'd5) begin errors++; $display("FAIL sel_reread: got %0d want 5", bus.rd_data_o); end
  endtask

  task automatic test_back_to_back();
    start_window(32'd2);
    tick();
    tick();
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %b want 1", bus.done_o); end
    bus.limit_i = 32'd3;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    checks++; if ({bus.running_o, bus.done_o} !== 2'b10) begin errors++; $display("FAIL b2b_restart: got %b want 10", {bus.running_o, bus.done_o}); end
    tick();
    tick();
    tick();
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b want 1", bus.done_o); end
    bus.sel_i = 4'd0; tick();
    checks++; if (bus.rd_data_o !== 32'd3) begin errors++; $display("FAIL b2b_cycles: got %0d want 3", bus.rd_data_o); end
  endtask

  initial begin
    test_reset();
    test_limit();
    test_stop();
    test_saturation();
    test_clear();
    test_reset_midrun();
    test_sel_range();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
